// File: rtl/rubiks_lcd_pkg.sv
// Shared types and constants for the Rubik's cube LT24 scan path.
package rubiks_lcd_pkg;
  localparam int LCD_WIDTH    = 320;
  localparam int LCD_HEIGHT   = 240;
  localparam int X_W          = 9;
  localparam int Y_W          = 8;
  localparam int CUBE_STATE_W = 144;

  localparam logic [15:0] COL_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    DONE
  } scan_state_t;
endpackage

// File: rtl/rubiks_lcd_frame_scanner_pixel_scan_counter.sv
// Raster x/y counter: x runs across a row, then wraps and bumps y; y saturates on the last row.
module pixel_scan_counter
  import rubiks_lcd_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_MAX);
  assign y_end = (y == Y_MAX);
  assign last  = x_end && y_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        if (!y_end) y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rubiks_lcd_frame_scanner.sv
// Frame scanner: sweeps the panel, samples the colour generator once per pixel and
// pushes each pixel to the LT24 write port over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a request, a pending request or a cube_state change
// SCAN  | sample pixel_colour and the current x/y into the lcd_* registers
// WRITE | offer the pixel, hold it until lcd_pixelReady
// DONE  | one-cycle frame_done, counter back to origin
module rubiks_lcd_frame_scanner
  import rubiks_lcd_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CUBE_STATE_W-1:0] cube_state,
  input  logic                    frame_request,
  input  logic [15:0]             pixel_colour,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [CUBE_STATE_W-1:0] cube_state_snap,
  output logic [X_W-1:0]          lcd_xAddr,
  output logic [Y_W-1:0]          lcd_yAddr,
  output logic [15:0]             lcd_pixelData,
  output logic                    lcd_pixelWrite,
  input  logic                    lcd_pixelReady,
  output logic                    busy,
  output logic                    frame_done
);

  scan_state_t state;
  scan_state_t state_nxt;

  logic pending;
  logic start;
  logic cnt_clear;
  logic advance;
  logic last;
  logic handshake;

  pixel_scan_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .advance(advance),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  assign handshake = lcd_pixelWrite && lcd_pixelReady;

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    cnt_clear  = 1'b0;
    advance    = 1'b0;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        // a request and a snapshot mismatch in the same cycle still start only one frame
        if (frame_request || pending || (cube_state != cube_state_snap)) begin
          start     = 1'b1;
          cnt_clear = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: state_nxt = WRITE;
      WRITE: begin
        if (handshake) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = SCAN;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        cnt_clear  = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= 1'b0;
      cube_state_snap <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        pending         <= 1'b0;
        cube_state_snap <= cube_state;
      end else if (frame_request && (state != IDLE)) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lcd_xAddr      <= '0;
      lcd_yAddr      <= '0;
      lcd_pixelData  <= '0;
      lcd_pixelWrite <= 1'b0;
    end else if (state == SCAN) begin
      lcd_xAddr      <= x;
      lcd_yAddr      <= y;
      lcd_pixelData  <= pixel_colour;
      lcd_pixelWrite <= 1'b1;
    end else if ((state == WRITE) && handshake) begin
      lcd_pixelWrite <= 1'b0;
    end
  end

endmodule
